// File: rtl/regfile_bypass.sv
// Register file with hardwired-zero entries, a sequential clear sequencer and
// optional same-cycle forwarding of an accepted write to both read ports.
module regfile_bypass #(
    parameter int                  DATA_W    = 16,
    parameter int                  ADDR_W    = 3,
    parameter int                  NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0] ZERO_MASK = 8'b0100_0001,
    parameter int                  BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] r_addr1,
    input  logic [ADDR_W-1:0] r_addr2,
    output logic [DATA_W-1:0] out_port1,
    output logic [DATA_W-1:0] out_port2,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Addresses that can never be written and always read as zero: the
    // hardwired registers plus every address past the last real register.
    localparam logic [DEPTH-1:0] BLOCKED = DEPTH'(ZERO_MASK) | ({DEPTH{1'b1}} << NUM_REGS);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_accept;
    logic              fwd1;
    logic              fwd2;
    logic [DATA_W-1:0] rd_vec [DEPTH];

    assign wr_accept = we && (state == IDLE) && !BLOCKED[w_addr];
    assign busy      = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= we && !wr_accept;
            case (state)
                CLEAR: begin
                    if (clr_idx == ADDR_W'(NUM_REGS - 1)) begin
                        state   <= IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + ADDR_W'(1);
                    end
                end
                default: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the clear sequence zeroes it.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (BLOCKED[i]) begin : g_zero
            assign rd_vec[i] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] q;
            always_ff @(posedge clk) begin
                if (state == CLEAR && clr_idx == ADDR_W'(i)) begin
                    q <= '0;
                end else if (wr_accept && w_addr == ADDR_W'(i)) begin
                    q <= wdata;
                end
            end
            assign rd_vec[i] = q;
        end
    end

    assign fwd1 = (BYPASS != 0) && wr_accept && (w_addr == r_addr1);
    assign fwd2 = (BYPASS != 0) && wr_accept && (w_addr == r_addr2);

    assign out_port1 = (state == CLEAR || BLOCKED[r_addr1]) ? '0 :
                       (fwd1 ? wdata : rd_vec[r_addr1]);
    assign out_port2 = (state == CLEAR || BLOCKED[r_addr2]) ? '0 :
                       (fwd2 ? wdata : rd_vec[r_addr2]);

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: default build, a BYPASS=0 twin sharing its inputs,
// and a 5-register 32-bit build, all checked against a simple array model.
module tb_regfile_bypass;

    localparam int         NR = 8;
    localparam logic [7:0] ZM = 8'b0100_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr_req, we;
    logic [2:0]  w_addr, r_addr1, r_addr2;
    logic [15:0] wdata, out_port1, out_port2, nb_out1, nb_out2;
    logic        busy, wr_drop, nb_busy, nb_wr_drop;

    logic        clr5, we5, busy5, drop5;
    logic [2:0]  wa5, ra5_1, ra5_2;
    logic [31:0] wd5, o5_1, o5_2;

    regfile_bypass u_dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .w_addr(w_addr), .wdata(wdata),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .out_port1(out_port1), .out_port2(out_port2),
        .busy(busy), .wr_drop(wr_drop)
    );

    regfile_bypass #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .clr_req(clr_req), .we(we), .w_addr(w_addr), .wdata(wdata),
        .r_addr1(r_addr1), .r_addr2(r_addr2), .out_port1(nb_out1), .out_port2(nb_out2),
        .busy(nb_busy), .wr_drop(nb_wr_drop)
    );

    regfile_bypass #(.DATA_W(32), .NUM_REGS(5), .ZERO_MASK(5'b00001)) u_d5 (
        .clk(clk), .rst(rst), .clr_req(clr5), .we(we5), .w_addr(wa5), .wdata(wd5),
        .r_addr1(ra5_1), .r_addr2(ra5_2), .out_port1(o5_1), .out_port2(o5_2),
        .busy(busy5), .wr_drop(drop5)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mem [NR];
    int          clr_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit accept_now();
        return we && (clr_left == 0) && !ZM[w_addr];
    endfunction

    function automatic logic [15:0] exp_rd(input logic [2:0] a, input bit fwd);
        if (clr_left > 0 || ZM[a]) return 16'h0000;
        if (fwd && accept_now() && w_addr == a) return wdata;
        return mem[a];
    endfunction

    // One clock of the default/no-bypass pair: drive, check reads, clock, check flags.
    task automatic step(input logic s_we, input logic [2:0] s_wa, input logic [15:0] s_wd,
                        input logic [2:0] s_r1, input logic [2:0] s_r2, input logic s_clr);
        bit acc, drop;
        we = s_we; w_addr = s_wa; wdata = s_wd; r_addr1 = s_r1; r_addr2 = s_r2; clr_req = s_clr;
        #2;
        chk("out_port1", 32'(out_port1), 32'(exp_rd(r_addr1, 1'b1)));
        chk("out_port2", 32'(out_port2), 32'(exp_rd(r_addr2, 1'b1)));
        chk("nb_out1", 32'(nb_out1), 32'(exp_rd(r_addr1, 1'b0)));
        acc  = accept_now();
        drop = we && !acc;
        @(posedge clk);
        if (clr_left > 0) begin
            clr_left--;
        end else begin
            if (acc) mem[w_addr] = wdata;
            if (clr_req) begin
                clr_left = NR;
                foreach (mem[i]) mem[i] = 16'h0000;
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(clr_left > 0));
        chk("wr_drop", 32'(wr_drop), 32'(drop));
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b1; w_addr = 3'd5; wdata = 16'hA5A5; clr_req = 1'b0;
        #1;
        clr_left = NR;
        foreach (mem[i]) mem[i] = 16'h0000;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_out1", 32'(out_port1), 32'd0);
        chk("rst_out2", 32'(out_port2), 32'd0);
        chk("rst_wr_drop", 32'(wr_drop), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_wr_drop_held", 32'(wr_drop), 32'd0);
        chk("rst_busy_held", 32'(busy), 32'd1);
        rst = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr_req = 1'b0; we = 1'b0; w_addr = '0; wdata = '0; r_addr1 = '0; r_addr2 = '0;
        clr5 = 1'b0; we5 = 1'b0; wa5 = '0; wd5 = '0; ra5_1 = '0; ra5_2 = '0;
        #1;
        do_reset();

        // Reset release: 8-cycle clear on the default build, 5 on the small one.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), 1'b0);
            chk("busy5_release", 32'(busy5), 32'((i + 1) < 5));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'h0000, 3'(2 * i), 3'(2 * i + 1), 1'b0);

        // Forwarding on the write cycle, stored value afterwards.
        step(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0);

        // Hardwired-zero registers reject writes.
        step(1'b1, 3'd0, 16'h1234, 3'd0, 3'd6, 1'b0);
        step(1'b1, 3'd6, 16'h1234, 3'd6, 3'd0, 1'b0);
        step(1'b1, 3'd5, 16'h1234, 3'd5, 3'd6, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b0);

        // Load, clear request, writes during busy, everything zero afterwards.
        for (int a = 1; a < 8; a++) if (a != 6) step(1'b1, 3'(a), 16'(16'h0011 * a), 3'(a), 3'd3, 1'b0);
        for (int a = 0; a < 8; a += 2) step(1'b0, 3'd0, 16'h0000, 3'(a), 3'(a + 1), 1'b0);
        step(1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 3'($urandom), 16'($urandom), 3'(i), 3'd7, 1'b0);
        for (int a = 0; a < 8; a += 2) step(1'b0, 3'd0, 16'h0000, 3'(a), 3'(a + 1), 1'b0);

        // Write plus clear in the same cycle, then a reset four cycles into the clear.
        step(1'b1, 3'd4, 16'h4444, 3'd4, 3'd4, 1'b0);
        step(1'b1, 3'd2, 16'h7777, 3'd2, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'h0000, 3'd2, 3'd4, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 16'h0000, 3'd2, 3'd4, 1'b0);
        step(1'b0, 3'd0, 16'h0000, 3'd2, 3'd4, 1'b0);

        // Small build: out-of-range and zero registers, 32-bit data, 5-cycle clear.
        we5 = 1'b1; wa5 = 3'd6; wd5 = 32'hCAFE_F00D; ra5_1 = 3'd6; ra5_2 = 3'd6;
        #1;
        chk("d5_rd6", o5_1, 32'd0);
        idle();
        chk("d5_drop6", 32'(drop5), 32'd1);
        wa5 = 3'd3; wd5 = 32'h89AB_CDEF; ra5_1 = 3'd3; ra5_2 = 3'd6;
        #1;
        chk("d5_bypass3", o5_1, 32'h89AB_CDEF);
        idle();
        chk("d5_nodrop3", 32'(drop5), 32'd0);
        we5 = 1'b0; ra5_2 = 3'd3;
        #1;
        chk("d5_rd3_p1", o5_1, 32'h89AB_CDEF);
        chk("d5_rd3_p2", o5_2, 32'h89AB_CDEF);
        we5 = 1'b1; wa5 = 3'd0; ra5_1 = 3'd0;
        idle();
        chk("d5_drop0", 32'(drop5), 32'd1);
        we5 = 1'b0; clr5 = 1'b1;
        idle();
        clr5 = 1'b0;
        chk("d5_busy_start", 32'(busy5), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            idle();
            chk("d5_busy_clear", 32'(busy5), 32'(k < 5));
        end
        ra5_1 = 3'd3;
        #1;
        chk("d5_rd3_cleared", o5_1, 32'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            step(1'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of registers; legal range 2..2**ADDR_W.
REQ-004 SHALL have parameter ZERO_MASK, width NUM_REGS, default 8'b0100_0001; bit i=1 makes register i hardwired zero (default: $0, $6).
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 clk  input  1  single clock; all state updates on posedge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 clr_req  input  1  request a sequential clear of all registers.
REQ-009 we  input  1  write enable.
REQ-010 w_addr  input  ADDR_W  write address.
REQ-011 wdata  input  DATA_W  write data.
REQ-012 r_addr1, r_addr2  input  ADDR_W each  read addresses.
REQ-013 out_port1, out_port2  output  DATA_W each  read data, combinational.
REQ-014 busy  output  1  high while a clear sequence runs.
REQ-015 wr_drop  output  1  registered one-cycle pulse flagging a rejected write.

Function
REQ-016 SHALL implement FSM with states CLEAR and IDLE, plus clear index clr_idx (ADDR_W bits).
REQ-017 In CLEAR: each cycle SHALL write 0 to register clr_idx and increment clr_idx; at clr_idx==NUM_REGS-1 SHALL write 0 and go to IDLE on the same edge.
REQ-018 Clear duration SHALL be exactly NUM_REGS cycles; busy SHALL equal (state==CLEAR).
REQ-019 In IDLE, clr_req=1 SHALL move to CLEAR with clr_idx=0 on the next edge; clr_req in CLEAR SHALL be ignored (no restart).
REQ-020 A write is accepted iff we=1, state==IDLE, w_addr<NUM_REGS, and ZERO_MASK[w_addr]=0; accepted write updates register w_addr with wdata on the edge.
REQ-021 We=1 with any acceptance condition false SHALL leave all registers unchanged and set wr_drop=1 for the following cycle; otherwise wr_drop=0.
REQ-022 Simultaneous accepted write and clr_req in IDLE: write SHALL commit; clear starts next cycle and subsequently zeroes it.
REQ-023 Read port k SHALL output 0 when state==CLEAR, r_addr_k>=NUM_REGS, or ZERO_MASK[r_addr_k]=1.
REQ-024 Otherwise, if BYPASS=1 and write accepted this cycle with w_addr==r_addr_k, port k SHALL output wdata; else stored value of register r_addr_k.
REQ-025 Both read ports SHALL be independent; same address on both SHALL give identical data.
REQ-026 Hardwired-zero registers SHALL never hold nonzero storage (no write path to them).

Reset
REQ-027 rst=1 SHALL asynchronously force state=CLEAR, clr_idx=0, wr_drop=0; busy=1 and both read ports=0 immediately.
REQ-028 Register storage SHALL NOT be reset asynchronously; it is zeroed by the CLEAR sequence after rst deasserts (NUM_REGS cycles).
REQ-029 rst asserted mid-clear or mid-operation SHALL restart the clear from clr_idx=0.
REQ-030 While rst=1, writes SHALL be rejected without wr_drop (wr_drop held 0).

Verification
REQ-031 Reset release, defaults: deassert rst, drive we=0 -> busy=1 for exactly 8 cycles, then 0; all reads of r0..r7 return 0x0000.
REQ-032 Write/read with bypass: IDLE, we=1, w_addr=3, wdata=0xBEEF, r_addr1=3 -> out_port1=0xBEEF same cycle; next cycle we=0 -> still 0xBEEF; BYPASS=0 build -> 0x0000 in write cycle.
REQ-033 Zero registers: write 0x1234 to addr 0, then addr 6 -> wr_drop=1 one cycle after each; reads of 0 and 6 return 0x0000; addr 5 write of 0x1234 reads back 0x1234.
REQ-034 Clear request: regs 1..5,7 = 0x0011..0x0077; pulse clr_req -> busy high 8 cycles, reads 0 during busy, all 0x0000 after; we=1 during busy -> wr_drop=1, no update.
REQ-035 Mid-clear reset: assert rst during clr_idx=4 for 1 cycle -> clr_idx returns to 0, busy stays high a full 8 cycles after release.
REQ-036 Parameter sweep: DATA_W=32, NUM_REGS=5, ZERO_MASK=5'b00001 -> write to addr 6 rejected (wr_drop=1), read addr 6 = 0, clear lasts 5 cycles.
